cmd_packer: RTL
===============

CMD_PACKER -- requirements
Module: cmd_packer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning idle cycles allowed between bytes of one word before the partial word is discarded.
REQ-002 The block SHALL have parameter MAX_CMD, default 4, meaning the highest legal command code.
REQ-003 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port s_byte_data  input  8  incoming command byte, MSB-first within a word.
REQ-006 Port s_byte_valid  input  1  s_byte_data valid.
REQ-007 Port s_byte_ready  output  1  block accepts byte this cycle.
REQ-008 Port flush  input  1  single-cycle request to discard any partial or pending word.
REQ-009 Port fifo_full  input  1  command FIFO full.
REQ-010 Port fifo_wr_data  output  32  packed word: [31:24] command, [23:8] coarse, [7:0] fine.
REQ-011 Port fifo_wr_en  output  1  one-cycle write strobe to command FIFO.
REQ-012 Port err_cmd_count  output  8  count of words rejected for illegal command code.
REQ-013 Port err_timeout_count  output  8  count of partial words discarded by timeout.
REQ-014 Port state_out  output  8  current state encoding, for debug.

Function
REQ-015 States SHALL be S_COLLECT=0, S_CHECK=1, S_WRITE=2; any other value SHALL return to S_COLLECT with index cleared.
REQ-016 s_byte_ready SHALL equal (state==S_COLLECT), combinational from state only.
REQ-017 A byte SHALL be accepted when s_byte_valid and s_byte_ready are both high at a rising edge; the byte SHALL be shifted into the word LSB end, and the 2-bit index SHALL increment.
REQ-018 Acceptance of the 4th byte (index 3) SHALL move to S_CHECK and clear the index.
REQ-019 S_CHECK SHALL last one cycle: command byte <= MAX_CMD -> S_WRITE; otherwise err_cmd_count increments (saturating at 255) -> S_COLLECT, no write.
REQ-020 In S_WRITE with fifo_full low, fifo_wr_en SHALL be registered high for exactly the next cycle and state SHALL go to S_COLLECT; with fifo_full high, S_WRITE SHALL hold indefinitely.
REQ-021 fifo_wr_data SHALL be stable from entry to S_CHECK until the cycle after fifo_wr_en deasserts.
REQ-022 Latency: 4th byte accepted at edge N -> fifo_wr_en high in cycle N+3 when fifo_full is low.
REQ-023 Timeout counter SHALL run only in S_COLLECT with index>0, clear on every accepted byte, and on reaching TIMEOUT_CYCLES-1 SHALL clear index and increment err_timeout_count (saturating).
REQ-024 flush high SHALL clear index and timeout counter, force S_COLLECT, and suppress any write not yet strobed; flush SHALL win over simultaneous byte acceptance, timeout, or S_WRITE exit.
REQ-025 A byte presented with valid and a simultaneous flush SHALL be dropped, not accepted.
REQ-026 Timeout and byte acceptance on the same edge: acceptance SHALL win, no error counted.

Reset
REQ-027 On rst low: state=S_COLLECT, index=0, timeout counter=0, fifo_wr_data=0, fifo_wr_en=0, both error counts=0; s_byte_ready therefore 1.
REQ-028 Reset asserted mid-word or in S_WRITE SHALL discard the word with no write and no error count.

Structure
REQ-029 Command codes (reset_clock=0, send_pulse=1, set_period=2, set_phase_meas_mode=3, reset_phase_meas_mode=4) and state encodings SHALL live in shared package pulse_pkg, used also by the downstream pulse generator.
REQ-030 One sub-module sat_cnt8 (8-bit saturating incrementer with enable) SHALL be instantiated twice for the error counters.

Verification
REQ-031 Bytes 01 00 05 03 back-to-back, fifo_full=0 -> single fifo_wr_en with fifo_wr_data=0x01000503, three cycles after last byte.
REQ-032 Bytes 07 00 00 00 -> no write, err_cmd_count=1, s_byte_ready high again two cycles later.
REQ-033 TIMEOUT_CYCLES=16; bytes 02 00 then silence 20 cycles, then 02 00 00 0A -> err_timeout_count=1, one write of 0x0200000A.
REQ-034 Full word 00 00 00 00 with fifo_full=1 for 50 cycles -> s_byte_ready low, no strobe; fifo_full drops -> exactly one strobe.
REQ-035 Flush in S_WRITE with fifo_full=1, then word 04 00 00 00 -> only 0x04000000 written.
REQ-036 300 illegal words -> err_cmd_count saturates at 255; rst low mid-word -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared definitions for the command path: command codes and packer state encodings.
// Used by cmd_packer and by the downstream pulse generator.
package pulse_pkg;

  localparam logic [7:0] CMD_RESET_CLOCK           = 8'd0;
  localparam logic [7:0] CMD_SEND_PULSE            = 8'd1;
  localparam logic [7:0] CMD_SET_PERIOD            = 8'd2;
  localparam logic [7:0] CMD_SET_PHASE_MEAS_MODE   = 8'd3;
  localparam logic [7:0] CMD_RESET_PHASE_MEAS_MODE = 8'd4;

  localparam int unsigned StateW = 2;

  localparam logic [StateW-1:0] S_COLLECT = 2'd0;
  localparam logic [StateW-1:0] S_CHECK   = 2'd1;
  localparam logic [StateW-1:0] S_WRITE   = 2'd2;

  function automatic logic cmd_legal(input logic [7:0] cmd, input int unsigned max_cmd);
    return 32'(cmd) <= max_cmd;
  endfunction

endpackage

// File: rtl/sat_cnt8.sv
// 8-bit event counter that sticks at 255 instead of wrapping.
module sat_cnt8 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       inc_i,
  output logic [7:0] count_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else if (inc_i && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/cmd_packer.sv
// Packs four MSB-first command bytes into one 32-bit word, rejects illegal command
// codes, discards stalled partial words and writes good words into the command FIFO.
module cmd_packer
  import pulse_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned MAX_CMD        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_byte_data,
  input  logic        s_byte_valid,
  output logic        s_byte_ready,
  input  logic        flush,
  input  logic        fifo_full,
  output logic [31:0] fifo_wr_data,
  output logic        fifo_wr_en,
  output logic [7:0]  err_cmd_count,
  output logic [7:0]  err_timeout_count,
  output logic [7:0]  state_out
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [StateW-1:0] state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       word_q, word_d;
  logic [31:0]       data_q, data_d;
  logic              wr_en_q, wr_en_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              accept;
  logic              cmd_err_inc;
  logic              tmo_err_inc;

  assign s_byte_ready = (state_q == S_COLLECT);
  // A byte arriving alongside flush is dropped.
  assign accept = s_byte_valid && s_byte_ready && !flush;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    data_d      = data_q;
    tmo_d       = tmo_q;
    wr_en_d     = 1'b0;
    cmd_err_inc = 1'b0;
    tmo_err_inc = 1'b0;

    if (flush) begin
      state_d = S_COLLECT;
      idx_d   = 2'd0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (accept) begin
            word_d = {word_q[15:0], s_byte_data};
            tmo_d  = '0;
            if (idx_q == 2'd3) begin
              // Output word is frozen here until the next complete word arrives.
              data_d  = {word_q, s_byte_data};
              idx_d   = 2'd0;
              state_d = S_CHECK;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else if (idx_q != 2'd0) begin
            if (tmo_q == TmoLast) begin
              idx_d       = 2'd0;
              tmo_d       = '0;
              tmo_err_inc = 1'b1;
            end else begin
              tmo_d = tmo_q + TmoW'(1);
            end
          end else begin
            tmo_d = '0;
          end
        end
        S_CHECK: begin
          if (cmd_legal(data_q[31:24], MAX_CMD)) begin
            state_d = S_WRITE;
          end else begin
            cmd_err_inc = 1'b1;
            state_d     = S_COLLECT;
          end
        end
        S_WRITE: begin
          if (!fifo_full) begin
            wr_en_d = 1'b1;
            state_d = S_COLLECT;
          end
        end
        default: begin
          state_d = S_COLLECT;
          idx_d   = 2'd0;
          tmo_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_COLLECT;
      idx_q   <= 2'd0;
      word_q  <= 24'd0;
      data_q  <= 32'd0;
      wr_en_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      tmo_q   <= tmo_d;
    end
  end

  sat_cnt8 u_err_cmd_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .inc_i   (cmd_err_inc),
    .count_o (err_cmd_count)
  );

  sat_cnt8 u_err_tmo_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .inc_i   (tmo_err_inc),
    .count_o (err_timeout_count)
  );

  assign fifo_wr_data = data_q;
  assign fifo_wr_en   = wr_en_q;
  assign state_out    = {{(8 - StateW){1'b0}}, state_q};

endmodule
